// File: rtl/uart_cmd_mode_ctrl.sv
// Mode-flag bank driven by the UART command byte stream: per-flag set/clear bytes,
// a two-byte mask load with idle timeout, a status query, and change/error strobes.
module uart_cmd_mode_ctrl #(
  parameter int                   NUM_FLAGS      = 4,
  parameter logic [NUM_FLAGS-1:0] RESET_FLAGS    = 4'b0001,
  parameter logic [7:0]           ON_BASE        = 8'd69,
  parameter logic [7:0]           OFF_BASE       = 8'd101,
  parameter logic [7:0]           MASK_CHAR      = 8'd77,
  parameter logic [7:0]           QUERY_CHAR     = 8'd63,
  parameter int                   TIMEOUT_CYCLES = 1000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [7:0]           Cmd,
  input  logic                 CmdValid,
  output logic [NUM_FLAGS-1:0] Flags,
  output logic                 EchoChar,
  output logic                 ModeChanged,
  output logic                 StatusValid,
  output logic [7:0]           StatusByte,
  output logic                 CmdError
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_MASK = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s, cnt_inc_s;
  logic [NUM_FLAGS-1:0] flags_r, flags_s;
  logic [7:0]           status_byte_r, status_byte_s;
  logic                 mode_changed_r;
  logic                 status_valid_r, status_valid_s;
  logic                 cmd_error_r, cmd_error_s;

  // Next-state, next-flags and strobe decode for the IDLE / WAIT_MASK machine.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    flags_s        = flags_r;
    status_byte_s  = status_byte_r;
    status_valid_s = 1'b0;
    cmd_error_s    = 1'b0;
    cnt_inc_s      = (cnt_r >= CNT_MAX) ? cnt_r : cnt_r + CW'(1);
    case (state_r)
      IDLE: begin
        if (CmdValid) begin
          for (int i = 0; i < NUM_FLAGS; i++) begin
            if (Cmd == ON_BASE + 8'(i)) begin
              flags_s[i] = 1'b1;
            end else if (Cmd == OFF_BASE + 8'(i)) begin
              flags_s[i] = 1'b0;
            end else begin
              flags_s[i] = flags_r[i];
            end
          end
          if (Cmd == MASK_CHAR) begin
            state_s = WAIT_MASK;
            cnt_s   = '0;
          end else if (Cmd == QUERY_CHAR) begin
            status_valid_s = 1'b1;
            status_byte_s  = 8'(flags_r);
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_MASK: begin
        // A byte on the expiry cycle takes precedence over the timeout.
        if (CmdValid) begin
          flags_s = Cmd[NUM_FLAGS-1:0];
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_inc_s >= CNT_MAX) begin
          state_s     = IDLE;
          cnt_s       = cnt_inc_s;
          cmd_error_s = 1'b1;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, flag and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      flags_r        <= RESET_FLAGS;
      status_byte_r  <= 8'h00;
      mode_changed_r <= 1'b0;
      status_valid_r <= 1'b0;
      cmd_error_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      flags_r        <= flags_s;
      status_byte_r  <= status_byte_s;
      mode_changed_r <= (flags_s != flags_r);
      status_valid_r <= status_valid_s;
      cmd_error_r    <= cmd_error_s;
    end
  end

  assign Flags       = flags_r;
  assign EchoChar    = flags_r[0];
  assign ModeChanged = mode_changed_r;
  assign StatusValid = status_valid_r;
  assign StatusByte  = status_byte_r;
  assign CmdError    = cmd_error_r;

endmodule

// File: doc/uart_cmd_mode_ctrl.md
# uart_cmd_mode_ctrl

Parametrised mode-flag controller driven by the UART command byte stream. It generalises the single echo on/off toggle into a bank of `NUM_FLAGS` independently set/cleared mode flags. It adds a two-byte mask-load command with timeout, a status query, and change/error strobes. The block sits directly after the UART receiver; flag 0 drives the echo path, and higher flags gate other host-controlled features.

## Interface
- `NUM_FLAGS`, 4: number of mode flags, legal range 1..8.
- `RESET_FLAGS`, 4'b0001: flag values after reset, `NUM_FLAGS` bits wide. Bit 0 = 1, so echo is on at reset.
- `ON_BASE`, 8'd69 ('E'): flag i is set by byte `ON_BASE+i`.
- `OFF_BASE`, 8'd101 ('e'): flag i is cleared by byte `OFF_BASE+i`.
- `MASK_CHAR`, 8'd77 ('M'): introduces the mask-load command.
- `QUERY_CHAR`, 8'd63 ('?'): status query.
- `TIMEOUT_CYCLES`, 1000: maximum idle cycles allowed between `MASK_CHAR` and the mask byte, legal range ≥ 2.
- Constraint: the ranges `ON_BASE..ON_BASE+NUM_FLAGS-1` and `OFF_BASE..OFF_BASE+NUM_FLAGS-1`, `MASK_CHAR` and `QUERY_CHAR` are pairwise disjoint.

Ports:
- `Clock` in 1: single clock. All logic is on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Cmd` in 8: received byte.
- `CmdValid` in 1: one-cycle strobe, `Cmd` is valid. Back-to-back strobes are allowed.
- `Flags` out `NUM_FLAGS`: registered mode flags.
- `EchoChar` out 1: equal to `Flags[0]`.
- `ModeChanged` out 1: one-cycle pulse, coincident with any cycle in which `Flags` takes a new, different value.
- `StatusValid` out 1: one-cycle pulse answering a query.
- `StatusByte` out 8: `{(8-NUM_FLAGS)'b0, Flags}`, captured at the query. Holds its value between queries.
- `CmdError` out 1: one-cycle pulse on mask-load timeout.

## Operation
- Two-state FSM: IDLE and WAIT_MASK.
- **Commands in IDLE** (only bytes with `CmdValid`=1 are considered):
  - `ON_BASE+i`, i < `NUM_FLAGS`: `Flags[i]` <= 1. All other flags are unchanged.
  - `OFF_BASE+i`: `Flags[i]` <= 0.
  - `MASK_CHAR`: go to WAIT_MASK and clear the timeout counter.
  - `QUERY_CHAR`: `StatusByte` <= current `Flags`; pulse `StatusValid`.
  - Any other byte: ignored. No error is raised, because data bytes are legal on the stream.
- **WAIT_MASK:**
  - The next byte with `CmdValid`=1 is taken as the mask, whatever its value, including command characters. `Flags` <= `Cmd[NUM_FLAGS-1:0]`, upper bits are ignored, and the FSM returns to IDLE.
  - The counter increments on each cycle with `CmdValid`=0. When it reaches `TIMEOUT_CYCLES` the FSM returns to IDLE, `Flags` is unchanged, and `CmdError` pulses.
  - A byte that arrives in the same cycle the counter would expire wins: the mask is loaded and no error is raised.
- **`ModeChanged`** is asserted only when the new `Flags` differs from the old value. Setting a flag that is already set produces no pulse. Loading a mask equal to the current flags produces no pulse.
- **Counter width** is `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates and never wraps.
- **Reset**, including in the middle of WAIT_MASK:
  - State = IDLE, counter = 0, `Flags` = `RESET_FLAGS`, `StatusByte` = 0.
  - `ModeChanged`, `StatusValid` and `CmdError` = 0.
  - `Reset` has priority over `CmdValid` in the same cycle.

## Timing
- Latency is 1 cycle: a byte strobed at edge N is reflected in `Flags`/`EchoChar`, and pulses `ModeChanged`/`StatusValid`, after edge N, i.e. during cycle N+1.
- All outputs are registered. There is no combinational path from `Cmd`/`CmdValid` to any output.
- Throughput is one command per cycle. No backpressure; the block never stalls the receiver.
- The mask byte may arrive in the cycle immediately after `MASK_CHAR`.
- Timeout: with `MASK_CHAR` at edge N and no further bytes, `CmdError` is high in the cycle after edge N+`TIMEOUT_CYCLES`, and the FSM is in IDLE from then on.
- A query issued in the cycle after a flag change reports the updated flags.

## Test plan
- **Reset defaults:** assert `Reset` 2 cycles -> `Flags`=4'b0001, `EchoChar`=1, all pulses 0, `StatusByte`=0.
- **Toggle compatibility:** 'e' -> `EchoChar`=0 next cycle with `ModeChanged`=1; 'e' again -> no pulse; 'E' -> `EchoChar`=1, `ModeChanged`=1.
- **Independent flags, back-to-back:** 'G', 'F', 'e' on consecutive cycles -> `Flags` sequence 0101, 0111, 0110. 'I' (out of range for `NUM_FLAGS`=4) and 'x' -> no change, no pulses.
- **Mask load:** 'M' then 8'hFA on the next cycle -> `Flags`=4'b1010, `ModeChanged`=1. 'M', then 5 idle cycles, then 'E' -> `Flags`=4'b0101, where 'E' is treated as data.
- **Timeout:** `TIMEOUT_CYCLES`=8, 'M' then silence -> `CmdError` pulses exactly once, 8 cycles later, and `Flags` is unchanged. A following 'h' acts as a command. Separately, a byte arriving on the expiry cycle -> mask loaded and no error.
- **Query and reset mid-command:** '?' -> `StatusValid`=1 for one cycle, `StatusByte`=8'h01. 'M' then `Reset` -> IDLE. A subsequent 8'h65 ('e') clears echo rather than loading a mask.
